// File: rtl/stoch_decode_mat.sv
// Stochastic-to-binary decoder for a NUM_ROWS x NUM_COLS matrix of signed
// (pos/neg pair) bitstreams. One START launches a window of exactly
// 2**WINDOW_BITS cycles; each element accumulates (#pos ones - #neg ones)
// and the final counts are presented on y_o under a valid/ready handshake.
//
// Handshake: valid_o is high exactly while the FSM is in HOLD. A result is
// transferred on any rising clk edge where valid_o && ready_i. Once valid_o
// rises it stays high and y_o stays stable until that transfer (or reset).
// y_o keeps the last result after the transfer until the next window ends.
module stoch_decode_mat #(
  parameter int NUM_ROWS    = 2,
  parameter int NUM_COLS    = 2,
  parameter int WINDOW_BITS = 8
) (
  input  logic                                                  clk_i,
  input  logic                                                  rst_i,
  input  logic                                                  start_i,
  input  logic [NUM_ROWS-1:0][NUM_COLS-1:0]                     p_i,
  input  logic [NUM_ROWS-1:0][NUM_COLS-1:0]                     n_i,
  output logic [NUM_ROWS-1:0][NUM_COLS-1:0][WINDOW_BITS+1:0]    y_o,
  output logic                                                  valid_o,
  input  logic                                                  ready_i,
  output logic                                                  busy_o,
  output logic [1:0]                                            state_o
);

  localparam int AW = WINDOW_BITS + 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    HOLD  = 2'd2
  } state_t;

  state_t                                     state_q, state_d;
  logic [WINDOW_BITS-1:0]                     cnt_q, cnt_d;
  logic [NUM_ROWS-1:0][NUM_COLS-1:0][AW-1:0]  acc_q, acc_d;
  logic [NUM_ROWS-1:0][NUM_COLS-1:0][AW-1:0]  sum;
  logic [NUM_ROWS-1:0][NUM_COLS-1:0][AW-1:0]  y_q, y_d;
  logic                                       last_cycle;
  logic                                       launch;

  // The window ends when the counter has seen 2**WINDOW_BITS ACCUM cycles.
  assign last_cycle = (state_q == ACCUM) && (cnt_q == {WINDOW_BITS{1'b1}});
  // A new window starts from IDLE, or straight from HOLD when the result
  // is taken and another START is already waiting.
  assign launch = start_i && ((state_q == IDLE) || ((state_q == HOLD) && ready_i));

  // State register.
  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start_i) state_d = ACCUM;
      ACCUM:   if (last_cycle) state_d = HOLD;
      HOLD:    if (ready_i) state_d = start_i ? ACCUM : IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM outputs decoded from the current state.
  always_comb begin
    busy_o  = (state_q == ACCUM);
    valid_o = (state_q == HOLD);
    state_o = state_q;
  end

  // Per-element running sum including this cycle's +1/0/-1 sample.
  always_comb begin
    sum = acc_q;
    for (int r = 0; r < NUM_ROWS; r++) begin
      for (int c = 0; c < NUM_COLS; c++) begin
        case ({p_i[r][c], n_i[r][c]})
          2'b10:   sum[r][c] = acc_q[r][c] + {{(AW-1){1'b0}}, 1'b1};
          2'b01:   sum[r][c] = acc_q[r][c] + {AW{1'b1}};
          default: sum[r][c] = acc_q[r][c];
        endcase
      end
    end
  end

  // Accumulator, counter and result next-state.
  always_comb begin
    acc_d = acc_q;
    cnt_d = cnt_q;
    y_d   = y_q;
    if (launch) begin
      acc_d = '0;
      cnt_d = '0;
    end else if (state_q == ACCUM) begin
      acc_d = sum;
      // Wraps to zero exactly on the last cycle of the window.
      cnt_d = cnt_q + 1'b1;
      if (last_cycle) y_d = sum;
    end
  end

  // Datapath registers; reset clears everything, including a held result.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      acc_q <= '0;
      cnt_q <= '0;
      y_q   <= '0;
    end else begin
      acc_q <= acc_d;
      cnt_q <= cnt_d;
      y_q   <= y_d;
    end
  end

  assign y_o = y_q;

endmodule
